gauss_noise_acc: RTL and testbench

- Downstream consumer of the LFSR random-number stage (randn).
- Drives randn's `en` and sums 2**LOG2_N consecutive sign-extended samples, giving a near-Gaussian value by the central-limit theorem.
- The sum is arithmetic-shifted right by SHIFT and saturated to buffer_size bits.
- Produces one noise word per request, for injection into neuron membrane/current inputs of the hippocampal SNN.

---
 rtl/gauss_noise_acc_if.sv | 36 +++
 rtl/gauss_noise_acc.sv | 108 ++++++++++
 tb/tb_gauss_noise_acc.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/gauss_noise_acc_if.sv
`default_nettype none
// ============================================================================
//  Module   : gauss_noise_acc_if
//  Brief    : Request / sample / result bundle between a noise consumer,
//             the randn stage and gauss_noise_acc.
//  Revision : 1.0 - initial release
// ============================================================================
interface gauss_noise_acc_if #(
  parameter int BUFFER_SIZE = 16
);
  logic                   req;
  logic [BUFFER_SIZE-1:0] rnd_in;
  logic                   rnd_en;
  logic [BUFFER_SIZE-1:0] noise_out;
  logic                   noise_valid;
  logic                   busy;

  modport master (
    output req,
    output rnd_in,
    input  rnd_en,
    input  noise_out,
    input  noise_valid,
    input  busy
  );

  modport slave (
    input  req,
    input  rnd_in,
    output rnd_en,
    output noise_out,
    output noise_valid,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/gauss_noise_acc.sv
`default_nettype none
// ============================================================================
//  Module   : gauss_noise_acc
//  Brief    : Sums 2**LOG2_N randn samples, shifts by SHIFT and saturates,
//             yielding one near-Gaussian noise word per request.
//  Revision : 1.0 - initial release
// ============================================================================
module gauss_noise_acc #(
  parameter int BUFFER_SIZE = 16,
  parameter int LOG2_N      = 2,
  parameter int SHIFT       = 1
) (
  input  wire logic          clk,
  input  wire logic          init,
  gauss_noise_acc_if.slave   bus
);

  localparam int c_acc_w  = BUFFER_SIZE + LOG2_N;
  localparam int c_n_sum  = 1 << LOG2_N;

  localparam logic [LOG2_N-1:0] c_cnt_last = LOG2_N'(c_n_sum - 1);

  // Saturation bounds expressed in accumulator width.
  localparam logic signed [c_acc_w-1:0] c_acc_max =
    {{(LOG2_N+1){1'b0}}, {(BUFFER_SIZE-1){1'b1}}};
  localparam logic signed [c_acc_w-1:0] c_acc_min =
    {{(LOG2_N+1){1'b1}}, {(BUFFER_SIZE-1){1'b0}}};

  localparam logic [BUFFER_SIZE-1:0] c_out_max = {1'b0, {(BUFFER_SIZE-1){1'b1}}};
  localparam logic [BUFFER_SIZE-1:0] c_out_min = {1'b1, {(BUFFER_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic signed [c_acc_w-1:0]  r_acc;
  logic [LOG2_N-1:0]          r_cnt;
  logic [BUFFER_SIZE-1:0]     r_noise;
  logic                       r_valid;

  logic signed [c_acc_w-1:0]  w_sample;
  logic signed [c_acc_w-1:0]  w_sum;
  logic signed [c_acc_w-1:0]  w_shifted;
  logic [BUFFER_SIZE-1:0]     w_sat;
  logic                       w_start;
  logic                       w_last;

  assign w_sample  = {{LOG2_N{bus.rnd_in[BUFFER_SIZE-1]}}, bus.rnd_in};
  assign w_sum     = r_acc + w_sample;
  assign w_shifted = w_sum >>> SHIFT;

  assign w_start = ((r_state == S_IDLE) || (r_state == S_OUT)) && bus.req;
  assign w_last  = (r_state == S_ACC) && (r_cnt == c_cnt_last);

  always_comb begin
    w_sat = w_shifted[BUFFER_SIZE-1:0];
    if (w_shifted > c_acc_max) begin
      w_sat = c_out_max;
    end else if (w_shifted < c_acc_min) begin
      w_sat = c_out_min;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  w_state_nxt = bus.req ? S_ACC : S_IDLE;
      S_ACC:   w_state_nxt = w_last  ? S_OUT : S_ACC;
      S_OUT:   w_state_nxt = bus.req ? S_ACC : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_noise <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_last;
      if (w_start) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == S_ACC) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_noise <= w_sat;
      end
    end
  end

  // Enable is decoded from state so randn advances exactly on ACC edges.
  assign bus.rnd_en      = (r_state == S_ACC);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.noise_out   = r_noise;
  assign bus.noise_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_gauss_noise_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gauss_noise_acc
//  Brief    : Directed scoreboard bench; SHIFT=1 and SHIFT=0 instances share
//             stimulus and are checked against hand-computed results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gauss_noise_acc;

  logic clk;
  logic init;

  gauss_noise_acc_if #(.BUFFER_SIZE(16)) bus1 ();
  gauss_noise_acc_if #(.BUFFER_SIZE(16)) bus0 ();

  assign bus0.req    = bus1.req;
  assign bus0.rnd_in = bus1.rnd_in;

  gauss_noise_acc #(.BUFFER_SIZE(16), .LOG2_N(2), .SHIFT(1)) dut1 (
    .clk  (clk),
    .init (init),
    .bus  (bus1.slave)
  );

  gauss_noise_acc #(.BUFFER_SIZE(16), .LOG2_N(2), .SHIFT(0)) dut0 (
    .clk  (clk),
    .init (init),
    .bus  (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total;
  int          bad;
  int          en_cnt;
  int          busy_cnt;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req_v, $time);
    end
  endtask

  // One request; {e1,e0} are the SHIFT=1 / SHIFT=0 expected results.
  task automatic run_vec(input logic [15:0] s0, input logic [15:0] s1,
                         input logic [15:0] s2, input logic [15:0] s3,
                         input logic [15:0] e1, input logic [15:0] e0);
    exp_q.push_back({e1, e0});
    @(negedge clk); bus1.req = 1'b1; bus1.rnd_in = 16'h0000;
    @(negedge clk); bus1.req = 1'b0; bus1.rnd_in = s0;
    @(negedge clk); bus1.rnd_in = s1;
    @(negedge clk); bus1.rnd_in = s2;
    @(negedge clk); bus1.rnd_in = s3;
    @(negedge clk); bus1.rnd_in = 16'h0000;
    repeat (2) @(negedge clk);
    chk("hold1", bus1.noise_out, e1);
    chk("hold0", bus0.noise_out, e0);
  endtask

  initial begin
    logic [31:0] e;
    total    = 0;
    bad      = 0;
    en_cnt   = 0;
    busy_cnt = 0;
    init     = 1'b1;
    bus1.req    = 1'b0;
    bus1.rnd_in = 16'h0000;

    fork
      forever begin
        @(negedge clk);
        if (bus1.rnd_en) en_cnt++;
        if (bus1.busy)   busy_cnt++;
        if (bus1.noise_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got noise_out %h expected no pulse at %0t",
                     bus1.noise_out, $time);
          end else begin
            e = exp_q.pop_front();
            chk("noise_shift1", bus1.noise_out, e[31:16]);
            chk("noise_shift0", bus0.noise_out, e[15:0]);
            chk("valid_shift0", bus0.noise_valid, 1);
            chk("rnd_en_cycles", en_cnt, 4);
            chk("busy_cycles", busy_cnt, 5);
          end
          en_cnt   = 0;
          busy_cnt = 0;
        end else if (!bus1.busy) begin
          en_cnt   = 0;
          busy_cnt = 0;
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_noise", bus1.noise_out, 0);
    chk("rst_valid", bus1.noise_valid, 0);
    chk("rst_rnd_en", bus1.rnd_en, 0);
    chk("rst_busy", bus1.busy, 0);
    init = 1'b0;
    @(negedge clk);

    run_vec(16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h0004);
    run_vec(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFC);
    run_vec(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
    run_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_vec(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    run_vec(16'h1000, 16'h2000, 16'hF000, 16'h0003, 16'h1001, 16'h2003);
    run_vec(16'h4000, 16'h4000, 16'h0000, 16'hFFFF, 16'h3FFF, 16'h7FFF);
    run_vec(16'hC000, 16'hC000, 16'h0000, 16'h0000, 16'hC000, 16'h8000);

    // Back-to-back: samples 1..4, 6..9, 11..14, 16..19 are accumulated.
    exp_q.push_back({16'd5,  16'd10});
    exp_q.push_back({16'd15, 16'd30});
    exp_q.push_back({16'd25, 16'd50});
    exp_q.push_back({16'd35, 16'd70});
    @(negedge clk); bus1.req = 1'b1; bus1.rnd_in = 16'd0;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk); bus1.rnd_in = 16'(i);
    end
    @(negedge clk); bus1.req = 1'b0; bus1.rnd_in = 16'd20;
    repeat (4) @(negedge clk);

    // Abort during the second accumulation cycle.
    @(negedge clk); bus1.req = 1'b1; bus1.rnd_in = 16'h0000;
    @(negedge clk); bus1.req = 1'b0; bus1.rnd_in = 16'h0001;
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    chk("abort_rnd_en", bus1.rnd_en, 0);
    chk("abort_busy", bus1.busy, 0);
    chk("abort_noise1", bus1.noise_out, 0);
    chk("abort_noise0", bus0.noise_out, 0);
    chk("abort_valid", bus1.noise_valid, 0);
    repeat (3) @(negedge clk);

    run_vec(16'h0003, 16'h0005, 16'h0007, 16'h0009, 16'h000C, 16'h0018);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
